// File: rtl/request_encoder_pkg.sv
// Shared state type and sizing helpers for the request encoder and its
// round-robin picker.
package encoder_pkg;

  localparam int N_DEFAULT = 8;

  typedef enum logic {IDLE, HOLD} enc_state_t;

  // Code width for N request lines; N is a power of two, at least 2.
  function automatic int code_width(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/request_encoder_rr_pick.sv
// Combinational round-robin first-set finder: returns the first set bit of
// pending found scanning upward from ptr, wrapping modulo N.
module rr_pick
  import encoder_pkg::*;
#(
  parameter  int N = N_DEFAULT,
  localparam int W = code_width(N)
) (
  input  logic [N-1:0] pending,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         any
);

  logic [N-1:0] w_rot;
  logic [W-1:0] w_off;

  // w_rot[k] is line (ptr + k) mod N; W-bit addition gives the wrap for free.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_rot
      assign w_rot[gi] = pending[ptr + W'(gi)];
    end
  endgenerate

  always_comb begin
    w_off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = W'(i);
    end
  end

  assign idx = ptr + w_off;
  assign any = |pending;

endmodule

// File: rtl/request_encoder.sv
// Sequential N-to-log2(N) encoder: latches request pulses into a pending
// register and hands out one binary code per pending line, round-robin.
module request_encoder
  import encoder_pkg::*;
#(
  parameter  int N = N_DEFAULT,
  localparam int W = code_width(N)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] code,
  output logic [N-1:0] pending
);

  enc_state_t   r_state;
  logic [N-1:0] r_pending;
  logic [W-1:0] r_ptr;
  logic [W-1:0] r_code;
  logic         r_valid;

  logic [W-1:0] w_scan_ptr;
  logic [W-1:0] w_idx;
  logic         w_any;
  logic         w_handshake;
  logic         w_load;
  logic [N-1:0] w_load_mask;

  assign w_handshake = (r_state == HOLD) && ready;

  // On a handshake edge the next pick must already use the advanced pointer,
  // so scan from code+1 while holding rather than from the stale r_ptr.
  assign w_scan_ptr = (r_state == HOLD) ? r_code + 1'b1 : r_ptr;

  rr_pick #(.N(N)) u_pick (
    .pending (r_pending),
    .ptr     (w_scan_ptr),
    .idx     (w_idx),
    .any     (w_any)
  );

  assign w_load      = w_any && ((r_state == IDLE) || w_handshake);
  assign w_load_mask = w_load ? (N'(1) << w_idx) : '0;

  // A request arriving on the line being loaded re-arms it for a later pass.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_pending <= '0;
    else       r_pending <= (r_pending & ~w_load_mask) | req;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)            r_ptr <= '0;
    else if (w_handshake) r_ptr <= r_code + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_code  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_code  <= w_idx;
            r_valid <= 1'b1;
            r_state <= HOLD;
          end
        end
        HOLD: begin
          if (ready) begin
            if (w_any) begin
              r_code <= w_idx;
            end else begin
              r_valid <= 1'b0;
              r_state <= IDLE;
            end
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign valid   = r_valid;
  assign code    = r_code;
  assign pending = r_pending;

endmodule

// File: tb/tb_request_encoder.sv
// Self-checking bench for request_encoder: directed scenarios plus random
// traffic against a set-based round-robin reference model and a code scoreboard.
module tb_request_encoder;

  localparam int N = 8;

  logic         clk;
  logic         reset;
  logic [N-1:0] req;
  logic         ready;
  logic         valid;
  logic [2:0]   code;
  logic [N-1:0] pending;
  logic [N-1:0] dec;

  request_encoder #(.N(N)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .ready   (ready),
    .valid   (valid),
    .code    (code),
    .pending (pending)
  );

  // Downstream 3-to-8 decoder used for the loopback scenario.
  assign dec = N'(1) << code;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int lb_fail = 0;
  bit mon_en = 1'b0;

  // Reference model: set of waiting lines, line currently offered, next start.
  bit mp [N];
  int m_held = -1;
  int m_ptr  = 0;
  int exp_q [$];
  int m_vis = -1;            // line the DUT should be offering right now
  logic [N-1:0] m_pvis = '0; // pending set the DUT should show right now

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [N-1:0] pack_model();
    logic [N-1:0] p;
    for (int i = 0; i < N; i++) p[i] = mp[i];
    return p;
  endfunction

  task automatic model_step(input logic [N-1:0] r, input logic rd);
    bit found;
    int j;
    if (m_held >= 0 && rd) begin
      m_ptr  = (m_held + 1) % N;
      m_held = -1;
    end
    if (m_held < 0) begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (!found && mp[j]) begin
          found  = 1'b1;
          m_held = j;
          mp[j]  = 1'b0;
          exp_q.push_back(j);
        end
      end
    end
    for (int i = 0; i < N; i++) if (r[i]) mp[i] = 1'b1;
  endtask

  // Apply inputs for the coming edge, advance the model, return 1 unit after it.
  task automatic drive(input logic [N-1:0] r, input logic rd);
    req   = r;
    ready = rd;
    model_step(r, rd);
    @(posedge clk);
    #1;
    m_vis  = m_held;
    m_pvis = pack_model();
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) mp[i] = 1'b0;
    m_held = -1;
    m_ptr  = 0;
    exp_q.delete();
    m_vis  = -1;
    m_pvis = '0;
  endtask

  // Monitor: mid-cycle sample of outputs, scoreboard pop on each handshake.
  always @(negedge clk) begin : monitor
    int e;
    if (mon_en && !reset) begin
      chk("valid", {31'd0, valid}, {31'd0, (m_vis >= 0)});
      chk("pending", 32'(pending), 32'(m_pvis));
      if (valid) chk("code_vs_model", 32'(code), 32'(m_vis));
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL sb_underflow: got code %0d expected no handshake at %0t", code, $time);
        end else begin
          e = exp_q.pop_front();
          chk("sb_code", 32'(code), 32'(e));
        end
      end
    end
  end

  initial begin
    int cnt;
    logic [N-1:0] r;
    req   = '0;
    ready = 1'b0;
    reset = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_code", 32'(code), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Single request on line 5.
    drive(8'h20, 1'b1);
    chk("t2_pending", 32'(pending), 32'h20);
    chk("t2_idle", {31'd0, valid}, 32'd0);
    drive(8'h00, 1'b1);
    chk("t2_valid", {31'd0, valid}, 32'd1);
    chk("t2_code", 32'(code), 32'd5);
    drive(8'h00, 1'b1);
    chk("t2_done", {31'd0, valid}, 32'd0);
    chk("t2_pend0", 32'(pending), 32'd0);

    // Round-robin wrap from pointer 6.
    drive(8'h21, 1'b1);
    drive(8'h00, 1'b1);
    chk("t3_code0", 32'(code), 32'd0);
    drive(8'h00, 1'b1);
    chk("t3_code5", 32'(code), 32'd5);
    drive(8'h00, 1'b1);
    chk("t3_done", {31'd0, valid}, 32'd0);

    // Backpressure: code 2 held for four cycles, then code 3.
    drive(8'h0C, 1'b0);
    for (int c = 0; c < 4; c++) begin
      drive(8'h00, 1'b0);
      chk("t4_hold_valid", {31'd0, valid}, 32'd1);
      chk("t4_hold_code", 32'(code), 32'd2);
    end
    drive(8'h00, 1'b1);
    chk("t4_next_code", 32'(code), 32'd3);

    // Re-request of the line in flight.
    drive(8'h08, 1'b0);
    chk("t5_pend3", 32'(pending), 32'h08);
    chk("t5_held", 32'(code), 32'd3);
    drive(8'h00, 1'b1);
    chk("t5_again_valid", {31'd0, valid}, 32'd1);
    chk("t5_again_code", 32'(code), 32'd3);
    drive(8'h00, 1'b1);
    chk("t5_done", {31'd0, valid}, 32'd0);

    // Asynchronous reset while a code is offered.
    drive(8'h04, 1'b0);
    drive(8'h00, 1'b0);
    chk("t1_pre_code", 32'(code), 32'd2);
    reset = 1'b1;
    #1;
    chk("t1_valid", {31'd0, valid}, 32'd0);
    chk("t1_code", 32'(code), 32'd0);
    chk("t1_pending", 32'(pending), 32'd0);
    #1 reset = 1'b0;
    model_reset();

    // Loopback through the decoder for every line.
    for (int i = 0; i < N; i++) begin
      drive(N'(1) << i, 1'b1);
      drive(8'h00, 1'b1);
      chk("t6_valid", {31'd0, valid}, 32'd1);
      n_chk++;
      if (dec === (N'(1) << i)) n_pass++;
      else begin
        lb_fail++;
        $display("FAIL t6_loopback line %0d: got dec %b expected %b", i, dec, N'(1) << i);
      end
      drive(8'h00, 1'b1);
    end
    if (lb_fail != 0) begin
      mon_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $fatal(1, "loopback decode error on %0d line(s)", lb_fail);
    end

    // All lines pending drains in N cycles.
    drive(8'hFF, 1'b1);
    cnt = 0;
    for (int c = 0; c < N + 1; c++) begin
      drive(8'h00, 1'b1);
      if (valid) cnt++;
    end
    chk("full_drain_cycles", 32'(cnt), 32'(N));

    // Random traffic with random backpressure.
    for (int c = 0; c < 1500; c++) begin
      r = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
      drive(r, ($urandom_range(0, 3) != 0));
    end
    for (int c = 0; c < 3 * N; c++) drive(8'h00, 1'b1);
    mon_en = 1'b0;
    chk("end_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("end_idle", {31'd0, valid}, 32'd0);

    if (n_pass == n_chk) $display("@@@Passed");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
